// File: rtl/alu_seq_modes_pkg.sv
// Shared types for alu_seq_modes: operation codes, FSM states and the flag word.
package alu_seq_modes_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/hex7seg.sv
// Hex digit to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex7seg (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7f;
    case (digit)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'ha: seg = 7'h08;
      4'hb: seg = 7'h03;
      4'hc: seg = 7'h46;
      4'hd: seg = 7'h21;
      4'he: seg = 7'h06;
      4'hf: seg = 7'h0e;
      default: seg = 7'h7f;
    endcase
  end

endmodule

// File: rtl/alu_seq_modes.sv
// Button-driven sequential ALU: selector cycles the mode, start runs one operation
// (single cycle, or WIDTH-cycle shift-add for MUL); result and flags shown on six digits.
module alu_seq_modes
  import alu_seq_modes_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               selector,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] result,
  output logic [3:0]         flags,
  output logic [2:0]         mode,
  output logic               busy,
  output logic               done,
  output logic [6:0]         display1,
  output logic [6:0]         display2,
  output logic [6:0]         display3,
  output logic [6:0]         display4,
  output logic [6:0]         display5,
  output logic [6:0]         display6
);

  localparam int CW = $clog2(WIDTH);
  localparam int DW = (2 * WIDTH < 16) ? 2 * WIDTH : 16;

  // Handshake: a press is a 1->0 transition between the registered and current button level;
  // it is accepted only in IDLE, busy is high exactly while EXEC, done pulses one cycle on completion.
  logic sel_q, start_q;
  logic sel_edge, start_edge;
  assign sel_edge   = sel_q & ~selector;
  assign start_edge = start_q & ~start;

  state_e               state_q, state_d;
  op_e                  mode_q, op_mode_q;
  logic [WIDTH-1:0]     op_a_q, op_b_q, mul_plier_q;
  logic [2*WIDTH-1:0]   mul_acc_q, mul_mcand_q, mul_sum;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   result_q;
  flags_t               flags_q, alu_flags;
  logic                 done_q, last_step;

  assign last_step = (op_mode_q != OP_MUL) || (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_edge) state_d = ST_EXEC;
      ST_EXEC: if (last_step)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Combinational single-cycle ALU on the latched operands.
  logic [WIDTH:0]   add_ext, sub_ext, shl_ext, shr_ext;
  logic [CW-1:0]    shamt;
  logic [WIDTH-1:0] alu_res;

  assign shamt   = CW'(32'(op_b_q) % 32'(WIDTH));
  assign add_ext = {1'b0, op_a_q} + {1'b0, op_b_q};
  assign sub_ext = {1'b0, op_a_q} - {1'b0, op_b_q};
  // The extra bit catches the last bit shifted out; it stays 0 for a zero shift.
  assign shl_ext = {1'b0, op_a_q} << shamt;
  assign shr_ext = {op_a_q, 1'b0} >> shamt;

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (op_mode_q)
      OP_ADD: begin
        alu_res     = add_ext[WIDTH-1:0];
        alu_flags.c = add_ext[WIDTH];
        alu_flags.v = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (alu_res[WIDTH-1] != op_a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res     = sub_ext[WIDTH-1:0];
        alu_flags.c = sub_ext[WIDTH];
        alu_flags.v = (op_a_q[WIDTH-1] != op_b_q[WIDTH-1]) && (alu_res[WIDTH-1] != op_a_q[WIDTH-1]);
      end
      OP_AND: alu_res = op_a_q & op_b_q;
      OP_OR:  alu_res = op_a_q | op_b_q;
      OP_XOR: alu_res = op_a_q ^ op_b_q;
      OP_SHL: begin
        alu_res     = shl_ext[WIDTH-1:0];
        alu_flags.c = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res     = shr_ext[WIDTH:1];
        alu_flags.c = shr_ext[0];
      end
      default: alu_res = '0;
    endcase
    alu_flags.n = alu_res[WIDTH-1];
    alu_flags.z = (alu_res == '0);
  end

  assign mul_sum = mul_acc_q + (mul_plier_q[0] ? mul_mcand_q : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q       <= 1'b1;
      start_q     <= 1'b1;
      mode_q      <= OP_ADD;
      op_mode_q   <= OP_ADD;
      op_a_q      <= '0;
      op_b_q      <= '0;
      mul_plier_q <= '0;
      mul_acc_q   <= '0;
      mul_mcand_q <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      sel_q   <= selector;
      start_q <= start;
      done_q  <= 1'b0;
      if (state_q == ST_IDLE) begin
        // Start wins over a coincident selector press, which is dropped.
        if (start_edge) begin
          op_a_q      <= A;
          op_b_q      <= B;
          op_mode_q   <= mode_q;
          mul_plier_q <= B;
          mul_mcand_q <= {{WIDTH{1'b0}}, A};
          mul_acc_q   <= '0;
          cnt_q       <= '0;
        end else if (sel_edge) begin
          mode_q <= op_e'(mode_q + 3'd1);
        end
      end else if (op_mode_q == OP_MUL) begin
        if (last_step) begin
          result_q <= mul_sum;
          flags_q  <= '{n: mul_sum[2*WIDTH-1], z: (mul_sum == '0), c: 1'b0, v: 1'b0};
          done_q   <= 1'b1;
        end else begin
          mul_acc_q   <= mul_sum;
          mul_mcand_q <= mul_mcand_q << 1;
          mul_plier_q <= mul_plier_q >> 1;
          cnt_q       <= cnt_q + CW'(1);
        end
      end else begin
        result_q <= {{WIDTH{1'b0}}, alu_res};
        flags_q  <= alu_flags;
        done_q   <= 1'b1;
      end
    end
  end

  assign result = result_q;
  assign flags  = flags_q;
  assign mode   = mode_q;
  assign busy   = (state_q == ST_EXEC);
  assign done   = done_q;

  logic [15:0] res16;
  assign res16 = 16'(result_q[DW-1:0]);

  hex7seg u_hex1 (.digit({1'b0, mode_q}), .seg(display1));
  hex7seg u_hex2 (.digit(res16[3:0]),     .seg(display2));
  hex7seg u_hex3 (.digit(res16[7:4]),     .seg(display3));
  hex7seg u_hex4 (.digit(res16[11:8]),    .seg(display4));
  hex7seg u_hex5 (.digit(res16[15:12]),   .seg(display5));
  hex7seg u_hex6 (.digit(flags_q),        .seg(display6));

endmodule

// File: tb/tb_alu_seq_modes.sv
// Directed bench for alu_seq_modes at WIDTH=4 with hand-computed expectations.
module tb_alu_seq_modes;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset, selector, start;
  logic [W-1:0]   A, B;
  logic [2*W-1:0] result;
  logic [3:0]     flags;
  logic [2:0]     mode;
  logic           busy, done;
  logic [6:0]     display1, display2, display3, display4, display5, display6;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq_modes #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .selector(selector), .start(start),
    .A(A), .B(B), .result(result), .flags(flags), .mode(mode),
    .busy(busy), .done(done),
    .display1(display1), .display2(display2), .display3(display3),
    .display4(display4), .display5(display5), .display6(display6)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_sel(input int n);
    for (int i = 0; i < n; i++) begin
      selector = 1'b0;
      tick();
      selector = 1'b1;
      tick();
    end
  endtask

  // Returns one sample after the edge that accepts the start press.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    A = a;
    B = b;
    start = 1'b0;
    tick();
    start = 1'b1;
  endtask

  initial begin
    reset = 1'b1; selector = 1'b1; start = 1'b1; A = '0; B = '0;
    #1;
    tick();
    tick();
    chk("rst_result", 32'(result), 32'h00);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_mode", 32'(mode), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_disp1", 32'(display1), 32'h40);
    chk("rst_disp2", 32'(display2), 32'h40);
    chk("rst_disp6", 32'(display6), 32'h40);
    reset = 1'b0;
    tick();

    // ADD 0101 + 1100 = 1_0001
    do_start(4'b0101, 4'b1100);
    chk("add_busy_e0", 32'(busy), 32'h1);
    chk("add_done_e0", 32'(done), 32'h0);
    tick();
    chk("add_result", 32'(result), 32'h01);
    chk("add_flags", 32'(flags), 32'b0010);
    chk("add_done", 32'(done), 32'h1);
    chk("add_busy", 32'(busy), 32'h0);
    chk("add_disp2", 32'(display2), 32'h79);
    chk("add_disp3", 32'(display3), 32'h40);
    chk("add_disp6", 32'(display6), 32'h24);
    tick();
    chk("add_done_drop", 32'(done), 32'h0);

    // SUB
    press_sel(1);
    chk("sub_mode", 32'(mode), 32'h1);
    do_start(4'b1111, 4'b1111);
    tick();
    chk("sub0_result", 32'(result), 32'h00);
    chk("sub0_flags", 32'(flags), 32'b0100);
    do_start(4'b0000, 4'b1000);
    tick();
    chk("sub1_result", 32'(result), 32'h08);
    chk("sub1_flags", 32'(flags), 32'b1011);
    tick();

    // MUL 1010 * 1111 = 150, with mid-run A change, selector press and start press
    press_sel(1);
    chk("mul_mode", 32'(mode), 32'h2);
    do_start(4'b1010, 4'b1111);
    chk("mul_busy_e0", 32'(busy), 32'h1);
    A = 4'b0011;
    selector = 1'b0;
    tick();
    selector = 1'b1;
    start = 1'b0;
    chk("mul_busy_e1", 32'(busy), 32'h1);
    chk("mul_done_e1", 32'(done), 32'h0);
    tick();
    start = 1'b1;
    chk("mul_busy_e2", 32'(busy), 32'h1);
    chk("mul_done_e2", 32'(done), 32'h0);
    tick();
    chk("mul_busy_e3", 32'(busy), 32'h1);
    chk("mul_done_e3", 32'(done), 32'h0);
    tick();
    chk("mul_busy_e4", 32'(busy), 32'h0);
    chk("mul_done_e4", 32'(done), 32'h1);
    chk("mul_result", 32'(result), 32'h96);
    chk("mul_flags", 32'(flags), 32'b1000);
    chk("mul_mode_hold", 32'(mode), 32'h2);
    chk("mul_disp1", 32'(display1), 32'h24);
    chk("mul_disp2", 32'(display2), 32'h02);
    chk("mul_disp3", 32'(display3), 32'h10);
    chk("mul_disp6", 32'(display6), 32'h00);
    tick();
    chk("mul_done_once_a", 32'(done), 32'h0);
    chk("mul_idle_a", 32'(busy), 32'h0);
    tick();
    chk("mul_done_once_b", 32'(done), 32'h0);
    chk("mul_result_hold", 32'(result), 32'h96);

    // Same-cycle start + selector in mode 5: XOR runs, mode stays 5
    press_sel(3);
    chk("xor_mode_pre", 32'(mode), 32'h5);
    A = 4'b1100; B = 4'b1010;
    start = 1'b0; selector = 1'b0;
    tick();
    start = 1'b1; selector = 1'b1;
    chk("xor_busy", 32'(busy), 32'h1);
    tick();
    chk("xor_result", 32'(result), 32'h06);
    chk("xor_flags", 32'(flags), 32'b0000);
    chk("xor_done", 32'(done), 32'h1);
    chk("xor_mode", 32'(mode), 32'h5);

    // Fresh reset, then mode stepping and the remaining logic/shift ops
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    press_sel(3);
    chk("sel3_mode", 32'(mode), 32'h3);
    chk("sel3_disp1", 32'(display1), 32'h30);
    do_start(4'b1100, 4'b1010);
    tick();
    chk("and_result", 32'(result), 32'h08);
    chk("and_flags", 32'(flags), 32'b1000);
    press_sel(3);
    chk("shl_mode", 32'(mode), 32'h6);
    do_start(4'b1011, 4'b0101);
    tick();
    chk("shl_result", 32'(result), 32'h06);
    chk("shl_flags", 32'(flags), 32'b0010);
    press_sel(1);
    do_start(4'b1011, 4'b0100);
    tick();
    chk("shr0_result", 32'(result), 32'h0b);
    chk("shr0_flags", 32'(flags), 32'b1000);
    do_start(4'b1011, 4'b0110);
    tick();
    chk("shr2_result", 32'(result), 32'h02);
    chk("shr2_flags", 32'(flags), 32'b0010);
    press_sel(1);
    chk("sel8_wrap", 32'(mode), 32'h0);
    do_start(4'b0011, 4'b0100);
    tick();
    chk("add2_result", 32'(result), 32'h07);

    // Reset during the 2nd MUL cycle aborts with no done
    press_sel(2);
    do_start(4'b0011, 4'b0011);
    tick();
    reset = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_result", 32'(result), 32'h00);
    chk("abort_mode", 32'(mode), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'h0);
      chk("abort_idle", 32'(busy), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
